fios_dsp_word_mul_seq: RTL and testbench
========================================

Name: fios_dsp_word_mul_seq

Overview:
- Control-side driver for one non-cascaded 17x17 DSP48 multiply slice used by the FIOS datapath.
- Computes R = x*Y + t, where x is one 17-bit word, Y is an S-word operand streamed in, and t is a 17-bit addend. Output R is S+1 words.
- Generates the slice's A, B, C, CREG_en and OPMODE with internal pipeline alignment, chains carries through P>>17, and collects and reformats P into result words.

Parameters:
- S, 16: number of 17-bit Y words per operation (≥1).
- ABREG, 1: A/B register depth configured in the slice.
- MREG, 1: M register depth in the slice. ABREG+MREG ≥ 1.
- CREG, 1: C register depth in the slice (0 or 1, ≤ ABREG+MREG).
- LAT (localparam), 1+ABREG+MREG: cycles from A/B drive to valid P.

Ports:
- clock_i  in  1  single clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse that begins an operation; captures x_i and t_i.
- x_i  in  17  multiplier word.
- t_i  in  17  addend, added into word 0.
- y_valid_i  in  1  Y word available.
- y_i  in  17  Y word, LSW first.
- y_ready_o  out  1  Y word accepted when y_valid_i & y_ready_o.
- dsp_A_o  out  17  to slice A.
- dsp_B_o  out  17  to slice B.
- dsp_C_o  out  34  to slice C.
- dsp_CREG_en_o  out  1  to slice C register enable.
- dsp_OPMODE_o  out  7  to slice OPMODE (the slice registers it).
- dsp_P_i  in  34  from slice P.
- r_valid_o  out  1  result word valid.
- r_o  out  17  result word, LSW first.
- r_last_o  out  1  marks word S, the final carry word.
- busy_o  out  1  high from start acceptance until done.
- done_o  out  1  one-cycle pulse after r_last_o.

Behaviour:
- Reset values: all outputs 0. dsp_OPMODE_o resets to IDLE_OP (7'b0000000). FSM resets to IDLE. Slice internal registers are not reset; the first op of every operation uses Z=C, so stale P is irrelevant.
- OPMODE codes (Z[6:4], Y[3:2], X[1:0]):
  - MUL_C = 7'b0110101 (M + C), used for word 0 with C = {17'b0, t}.
  - MUL_CY = 7'b1100101 (M + P>>17), used for words 1..S-1.
  - HOLD = 7'b0100000 (P = P), issued on a bubble.
  - FLUSH = 7'b1100000 (P>>17).
  - IDLE_OP = 7'b0000000.
- Alignment: for an op whose A/B are driven in cycle n:
  - OPMODE is driven in cycle n+ABREG+MREG-1.
  - C with CREG_en=1 is driven in cycle n+ABREG+MREG-CREG.
  - P is valid in cycle n+LAT.
  - Implemented with tagged delay lines; the tag is {valid, last}.
- Width: x*y + carry ≤ 2^34-2^17, so it fits in P[33:0] and no overflow is possible. Result word = P[16:0]. The carry to the next word is P>>17 (< 2^17), handled inside the slice.
- FSM:
  - IDLE: start_i=1 → latch x,t; j=0; go to RUN. busy_o=1 from the next cycle.
  - RUN: y_ready_o=1.
    - On acceptance, issue a mul op: MUL_C if j=0, else MUL_CY; j++. When j=S-1 is accepted → FLUSH.
    - With no acceptance, issue HOLD with tag invalid. The carry chain is preserved across arbitrary bubbles.
  - FLUSH: issue the FLUSH op (A/B don't-care, driven 0) with tag last=1 → DRAIN.
  - DRAIN: wait for the last tag to emerge → IDLE.
- Result path:
  - Registered: r_valid_o/r_o/r_last_o appear in cycle n+LAT+1. There is no backpressure.
  - done_o pulses the cycle after r_last_o. busy_o drops in the same cycle done_o pulses.
- start_i while busy_o=1 is ignored.
- y_valid_i outside RUN is ignored (y_ready_o=0).
- Async reset mid-operation: everything clears immediately, no results are emitted, and the next start_i behaves normally.
- Exactly S+1 result words per operation, in order.

Decomposition:
- Package fios_dsp_pkg: W=17 word width, the OPMODE constants above, and a tag struct {valid, last}.
- One sub-module, fios_dsp_delay_line: a parameterised-depth, parameterised-width shift register with async active-low reset. Depth 0 means pass-through. It is used for the OPMODE, C/CREG_en and tag alignment.

Test Plan:
1. S=4, x=2, t=5, Y=[1,2,3,4], y_valid_i held high → r=[7,4,6,8,0]; r_last_o on the fifth word; done_o one cycle later; first r_valid_o exactly LAT+1 cycles after the first acceptance.
2. S=4, x=t=0x1FFFF, Y all 0x1FFFF → r=[0,0,0,0,0x1FFFF], proving maximum carry propagation without overflow.
3. Scenario 1 with y_valid_i low for 3 cycles between each word → identical r values with gaps in r_valid_o; HOLD observed on dsp_OPMODE_o during each bubble.
4. start_i pulsed again mid-RUN with different x,t → ignored; results match the original x,t.
5. reset_n_i asserted after 2 words accepted → all outputs 0 immediately with no further r_valid_o; then a fresh scenario-1 run → correct results.
6. Parameter sweep ABREG/MREG/CREG ∈ {(1,1,1), (0,1,0), (2,1,1)} against the slice model → scenario 1 results unchanged; latency equals LAT+1.

Source files
------------

// File: rtl/fios_dsp_pkg.sv
// Shared word width, DSP48 OPMODE codes and pipeline tag for the FIOS word multiplier.
package fios_dsp_pkg;

  localparam int unsigned W  = 17;
  localparam int unsigned PW = 2 * W;

  // OPMODE = {Z[6:4], Y[3:2], X[1:0]}
  localparam logic [6:0] OP_MUL_C  = 7'b0110101;
  localparam logic [6:0] OP_MUL_CY = 7'b1100101;
  localparam logic [6:0] OP_HOLD   = 7'b0100000;
  localparam logic [6:0] OP_FLUSH  = 7'b1100000;
  localparam logic [6:0] OP_IDLE   = 7'b0000000;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/fios_dsp_delay_line.sv
// Fixed-depth register pipeline with async reset; depth 0 is a wire.
module fios_dsp_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];

    always_comb begin
      sr_d[0] = d_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sr_d[k] = sr_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          sr_q[k] <= '0;
        end
      end else begin
        sr_q <= sr_d;
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/fios_dsp_word_mul_seq.sv
// Drives one 17x17 DSP48 slice to compute R = x*Y + t over S streamed Y words,
// aligning OPMODE/C/tag to the slice pipeline and collecting S+1 result words.
module fios_dsp_word_mul_seq
  import fios_dsp_pkg::*;
#(
  parameter int unsigned S     = 16,
  parameter int unsigned ABREG = 1,
  parameter int unsigned MREG  = 1,
  parameter int unsigned CREG  = 1
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          start_i,
  input  logic [16:0]   x_i,
  input  logic [16:0]   t_i,
  input  logic          y_valid_i,
  input  logic [16:0]   y_i,
  output logic          y_ready_o,
  output logic [16:0]   dsp_A_o,
  output logic [16:0]   dsp_B_o,
  output logic [33:0]   dsp_C_o,
  output logic          dsp_CREG_en_o,
  output logic [6:0]    dsp_OPMODE_o,
  input  logic [33:0]   dsp_P_i,
  output logic          r_valid_o,
  output logic [16:0]   r_o,
  output logic          r_last_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned LAT    = 1 + ABREG + MREG;
  localparam int unsigned OP_DLY = ABREG + MREG - 1;
  localparam int unsigned C_DLY  = ABREG + MREG - CREG;
  localparam int unsigned JW     = (S > 1) ? $clog2(S) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  t_q, t_d;
  logic          y_ready_q, y_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [6:0]    op_q, op_d;
  logic [PW-1:0] c_q, c_d;
  logic          cen_q, cen_d;
  tag_t          tag_q, tag_d;
  logic          r_valid_q, r_valid_d;
  logic [W-1:0]  r_q, r_d;
  logic          r_last_q, r_last_d;

  logic [6:0]    op_dly;
  logic [PW:0]   c_dly;
  tag_t          tag_p;
  logic          accept;
  logic          unused_p_hi;

  // Upper P bits are the carry, consumed inside the slice via the P>>17 path.
  assign unused_p_hi = ^dsp_P_i[PW-1:W];
  assign accept      = y_valid_i & y_ready_q;

  // Sequencer: issue one slice op per cycle and track result drain
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    x_d       = x_q;
    t_d       = t_q;
    busy_d    = busy_q;
    a_d       = '0;
    b_d       = '0;
    op_d      = OP_IDLE;
    c_d       = '0;
    cen_d     = 1'b0;
    tag_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          t_d     = t_i;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          a_d         = x_q;
          b_d         = y_i;
          tag_d.valid = 1'b1;
          if (j_q == '0) begin
            op_d  = OP_MUL_C;
            c_d   = {{W{1'b0}}, t_q};
            cen_d = 1'b1;
          end else begin
            op_d  = OP_MUL_CY;
          end
          if (j_q == JW'(S - 1)) begin
            state_d = ST_FLUSH;
          end else begin
            j_d = j_q + JW'(1);
          end
        end else begin
          // Bubble: P holds, so the pending carry survives any gap length
          op_d = OP_HOLD;
        end
      end
      ST_FLUSH: begin
        op_d        = OP_FLUSH;
        tag_d.valid = 1'b1;
        tag_d.last  = 1'b1;
        state_d     = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_last_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    y_ready_d = (state_d == ST_RUN);
    r_valid_d = tag_p.valid;
    r_d       = dsp_P_i[W-1:0];
    r_last_d  = tag_p.last;
    done_d    = r_last_q;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      j_q       <= '0;
      x_q       <= '0;
      t_q       <= '0;
      y_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_IDLE;
      c_q       <= '0;
      cen_q     <= 1'b0;
      tag_q     <= '0;
      r_valid_q <= 1'b0;
      r_q       <= '0;
      r_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      x_q       <= x_d;
      t_q       <= t_d;
      y_ready_q <= y_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      c_q       <= c_d;
      cen_q     <= cen_d;
      tag_q     <= tag_d;
      r_valid_q <= r_valid_d;
      r_q       <= r_d;
      r_last_q  <= r_last_d;
    end
  end

  // Align OPMODE, C and the result tag to the slice's internal register depths
  fios_dsp_delay_line #(.DEPTH(OP_DLY), .WIDTH(7)) u_op_dly (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .d_i   (op_q),
    .q_o   (op_dly)
  );

  fios_dsp_delay_line #(.DEPTH(C_DLY), .WIDTH(PW + 1)) u_c_dly (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .d_i   ({cen_q, c_q}),
    .q_o   (c_dly)
  );

  fios_dsp_delay_line #(.DEPTH(LAT), .WIDTH(TAG_W)) u_tag_dly (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .d_i   (tag_q),
    .q_o   (tag_p)
  );

  assign y_ready_o     = y_ready_q;
  assign dsp_A_o       = a_q;
  assign dsp_B_o       = b_q;
  assign dsp_OPMODE_o  = op_dly;
  assign dsp_CREG_en_o = c_dly[PW];
  assign dsp_C_o       = c_dly[PW-1:0];
  assign r_valid_o     = r_valid_q;
  assign r_o           = r_q;
  assign r_last_o      = r_last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_fios_dsp_word_mul_seq.sv
// Directed bench: three sequencer instances (ABREG,MREG,CREG) = (1,1,1),(0,1,0),(2,1,1),
// each driving its own behavioural DSP48 slice, all fed the same stimulus.
module tb_fios_dsp_word_mul_seq;

  localparam int NI = 3;
  localparam int S  = 4;

  typedef logic [16:0] word4_t [4];
  typedef logic [16:0] res_t [5];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, y_valid;
  logic [16:0] x, t, y;

  logic        y_ready [NI];
  logic [16:0] dsp_a   [NI];
  logic [16:0] dsp_b   [NI];
  logic [33:0] dsp_c   [NI];
  logic        creg_en [NI];
  logic [6:0]  opmode  [NI];
  logic        r_valid [NI];
  logic [16:0] r       [NI];
  logic        r_last  [NI];
  logic        busy    [NI];
  logic        done    [NI];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned AB = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
    localparam int unsigned MR = 1;
    localparam int unsigned CR = (g == 1) ? 0 : 1;

    logic [33:0] p_q = '0;
    logic [33:0] c_q = '0;
    logic [6:0]  op_q = '0;
    logic [16:0] a_sr [4];
    logic [16:0] b_sr [4];
    logic [33:0] m_sr [4];
    logic [16:0] a_eff, b_eff;
    logic [33:0] m_now, m_eff, c_eff;

    fios_dsp_word_mul_seq #(.S(S), .ABREG(AB), .MREG(MR), .CREG(CR)) u_dut (
      .clock_i       (clk),
      .reset_n_i     (rst_n),
      .start_i       (start),
      .x_i           (x),
      .t_i           (t),
      .y_valid_i     (y_valid),
      .y_i           (y),
      .y_ready_o     (y_ready[g]),
      .dsp_A_o       (dsp_a[g]),
      .dsp_B_o       (dsp_b[g]),
      .dsp_C_o       (dsp_c[g]),
      .dsp_CREG_en_o (creg_en[g]),
      .dsp_OPMODE_o  (opmode[g]),
      .dsp_P_i       (p_q),
      .r_valid_o     (r_valid[g]),
      .r_o           (r[g]),
      .r_last_o      (r_last[g]),
      .busy_o        (busy[g]),
      .done_o        (done[g])
    );

    // Behavioural slice: AB regs -> multiply -> M regs -> P register, OPMODE registered once
    assign a_eff = (AB == 0) ? dsp_a[g] : a_sr[(AB == 0) ? 0 : AB - 1];
    assign b_eff = (AB == 0) ? dsp_b[g] : b_sr[(AB == 0) ? 0 : AB - 1];
    assign m_now = 34'(a_eff) * 34'(b_eff);
    assign m_eff = (MR == 0) ? m_now : m_sr[(MR == 0) ? 0 : MR - 1];
    assign c_eff = (CR == 0) ? dsp_c[g] : c_q;

    always @(posedge clk) begin
      a_sr[0] <= dsp_a[g];
      b_sr[0] <= dsp_b[g];
      m_sr[0] <= m_now;
      for (int k = 1; k < 4; k++) begin
        a_sr[k] <= a_sr[k-1];
        b_sr[k] <= b_sr[k-1];
        m_sr[k] <= m_sr[k-1];
      end
      if (creg_en[g]) c_q <= dsp_c[g];
      op_q <= opmode[g];
      case (op_q)
        7'b0110101: p_q <= m_eff + c_eff;
        7'b1100101: p_q <= m_eff + (p_q >> 17);
        7'b0100000: p_q <= p_q;
        7'b1100000: p_q <= p_q >> 17;
        default:    p_q <= '0;
      endcase
    end
  end

  // Monitor state, cleared on request between scenarios
  logic        clr;
  logic [16:0] cap      [NI][8];
  logic        cap_last [NI][8];
  int cap_n [NI], first_acc [NI], first_rv [NI], last_cyc [NI];
  int done_cyc [NI], done_cnt [NI], hold_cnt [NI];
  logic busy_at_done [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (clr) begin
        cap_n[i] = 0; first_acc[i] = -1; first_rv[i] = -1; last_cyc[i] = -1;
        done_cyc[i] = -1; done_cnt[i] = 0; hold_cnt[i] = 0; busy_at_done[i] = 1'b1;
      end else begin
        if (y_valid && y_ready[i] && first_acc[i] < 0) first_acc[i] = cyc + 1;
        if (opmode[i] == 7'b0100000) hold_cnt[i]++;
        if (r_valid[i]) begin
          if (cap_n[i] < 8) begin
            cap[i][cap_n[i]]      = r[i];
            cap_last[i][cap_n[i]] = r_last[i];
          end
          cap_n[i]++;
          if (first_rv[i] < 0) first_rv[i] = cyc;
          if (r_last[i]) last_cyc[i] = cyc;
        end
        if (done[i]) begin
          done_cyc[i] = cyc;
          done_cnt[i]++;
          busy_at_done[i] = busy[i];
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int inst, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic logic [127:0] all_outs(input int i);
    return 128'({busy[i], y_ready[i], r_valid[i], r[i], r_last[i], done[i],
                 dsp_a[i], dsp_b[i], dsp_c[i], creg_en[i], opmode[i]});
  endfunction

  task automatic new_scn();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic start_op(input logic [16:0] xv, input logic [16:0] tv);
    start = 1'b1; x = xv; t = tv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NI; i++) chk("busy_after_start", i, 128'(busy[i]), 128'(1));
  endtask

  task automatic send_words(input word4_t w, input int gap, input bit mid_start, input int nmax);
    chk("ready_in_run", 0, 128'(y_ready[0]), 128'(1));
    for (int k = 0; k < nmax; k++) begin
      y_valid = 1'b1;
      y = w[k];
      if (mid_start && k == 2) begin
        start = 1'b1; x = 17'd7; t = 17'd9;
      end
      @(posedge clk); #1;
      start = 1'b0;
      y_valid = 1'b0;
      if (k < nmax - 1) begin
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_within_budget", 0, 128'(n < 100), 128'(1));
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_run(input string tag, input res_t e);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_count"}, i, 128'(cap_n[i]), 128'(5));
      for (int w = 0; w < 5; w++) begin
        chk({tag, "_word"}, i * 10 + w, 128'(cap[i][w]), 128'(e[w]));
        chk({tag, "_last"}, i * 10 + w, 128'(cap_last[i][w]), 128'(w == 4));
      end
      chk({tag, "_done_after_last"}, i, 128'(done_cyc[i] - last_cyc[i]), 128'(1));
      chk({tag, "_done_once"}, i, 128'(done_cnt[i]), 128'(1));
      chk({tag, "_busy_at_done"}, i, 128'(busy_at_done[i]), 128'(0));
      chk({tag, "_latency"}, i, 128'(first_rv[i] - first_acc[i]), 128'(exp_lat(i)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    word4_t w1, wmax;
    res_t   e1, e2;
    w1   = '{17'd1, 17'd2, 17'd3, 17'd4};
    wmax = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
    e1   = '{17'd7, 17'd4, 17'd6, 17'd8, 17'd0};
    e2   = '{17'd0, 17'd0, 17'd0, 17'd0, 17'h1FFFF};

    rst_n = 1'b0; start = 1'b0; x = '0; t = '0; y_valid = 1'b0; y = '0; clr = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < NI; i++) chk("reset_outputs", i, all_outs(i), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic streaming run
    new_scn();
    start_op(17'd2, 17'd5);
    send_words(w1, 0, 1'b0, 4);
    wait_done();
    check_run("s1", e1);
    for (int i = 0; i < NI; i++) chk("s1_no_hold", i, 128'(hold_cnt[i]), 128'(0));

    // 2: maximum carry propagation
    new_scn();
    start_op(17'h1FFFF, 17'h1FFFF);
    send_words(wmax, 0, 1'b0, 4);
    wait_done();
    check_run("s2", e2);

    // 3: bubbles between words
    new_scn();
    start_op(17'd2, 17'd5);
    send_words(w1, 3, 1'b0, 4);
    wait_done();
    check_run("s3", e1);
    for (int i = 0; i < NI; i++) chk("s3_hold_count", i, 128'(hold_cnt[i]), 128'(9));

    // 4: start pulsed mid-run is ignored
    new_scn();
    start_op(17'd2, 17'd5);
    send_words(w1, 1, 1'b1, 4);
    wait_done();
    check_run("s4", e1);

    // 5: async reset mid-operation, then a clean run
    new_scn();
    start_op(17'd2, 17'd5);
    send_words(w1, 0, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) chk("s5_reset_outputs", i, all_outs(i), 128'(0));
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    for (int i = 0; i < NI; i++) begin
      chk("s5_no_results", i, 128'(cap_n[i]), 128'(0));
      chk("s5_no_done", i, 128'(done_cnt[i]), 128'(0));
      chk("s5_idle_busy", i, 128'(busy[i]), 128'(0));
    end
    new_scn();
    start_op(17'd2, 17'd5);
    send_words(w1, 0, 1'b0, 4);
    wait_done();
    check_run("s5_fresh", e1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
